// File: rtl/ring_inject_arb.sv
// Packet-level arbiter merging transit ring traffic and local injection onto ring-out.
// Transit has priority; a weight counter forces a local grant after tw transit packets.
`ifndef PRW_SZ
`define PRW_SZ 64
`endif

module ring_inject_arb #(
    parameter int rdp_sz = `PRW_SZ,
    parameter int tw     = 4,
    parameter int cnt_sz = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tr_srdy,
    output logic              tr_drdy,
    input  logic [rdp_sz-1:0] tr_data,
    input  logic              tr_eop,
    input  logic              lc_srdy,
    output logic              lc_drdy,
    input  logic [rdp_sz-1:0] lc_data,
    input  logic              lc_eop,
    output logic              ro_srdy,
    input  logic              ro_drdy,
    output logic [rdp_sz-1:0] ro_data,
    output logic              ro_eop,
    output logic [1:0]        owner,
    output logic [15:0]       lc_wait_cyc
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOCK_TR = 2'b01,
        LOCK_LC = 2'b10
    } state_t;

    localparam logic [cnt_sz-1:0] TW = cnt_sz'(tw);

    state_t            state_q, state_d;
    logic [cnt_sz-1:0] wcnt_q, wcnt_d;
    logic [15:0]       wait_q, wait_d;
    logic              sel_tr, sel_lc, xfer;

    // Source selection; in IDLE this is the arbitration decision for a first word.
    always_comb begin
        sel_tr = 1'b0;
        sel_lc = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (tr_srdy && (!lc_srdy || wcnt_q < TW))
                        sel_tr = 1'b1;
                    else if (lc_srdy)
                        sel_lc = 1'b1;
                end
                LOCK_TR: sel_tr = 1'b1;
                LOCK_LC: sel_lc = 1'b1;
                default: ;
            endcase
        end
    end

    assign ro_srdy = (sel_tr & tr_srdy) | (sel_lc & lc_srdy);
    assign ro_data = sel_lc ? lc_data : tr_data;
    assign ro_eop  = sel_lc ? lc_eop  : tr_eop;
    assign tr_drdy = sel_tr & ro_drdy;
    assign lc_drdy = sel_lc & ro_drdy;
    assign xfer    = ro_srdy & ro_drdy;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wait_d  = wait_q;
        if (lc_srdy && !lc_drdy && wait_q != 16'hFFFF)
            wait_d = wait_q + 16'd1;
        if (xfer) begin
            case (state_q)
                IDLE: begin
                    // Single-word packets never take the lock.
                    if (!ro_eop)
                        state_d = sel_lc ? LOCK_LC : LOCK_TR;
                    if (sel_lc)
                        wcnt_d = '0;
                    else if (lc_srdy && wcnt_q < TW)
                        wcnt_d = wcnt_q + cnt_sz'(1);
                end
                default: begin
                    if (ro_eop)
                        state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            wait_q  <= wait_d;
        end
    end

    assign owner       = reset ? 2'b00 : state_q;
    assign lc_wait_cyc = wait_q;

endmodule

// File: tb/tb_ring_inject_arb.sv
// Directed vector bench for ring_inject_arb: tw=2 instance driven from a table,
// plus hand sequences for reset mid-packet and a tw=0 instance.
module tb_ring_inject_arb;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         tr_srdy, tr_eop, lc_srdy, lc_eop, ro_drdy;
    logic [W-1:0] tr_data, lc_data;

    logic         tr_drdy, lc_drdy, ro_srdy, ro_eop;
    logic [W-1:0] ro_data;
    logic [1:0]   owner;
    logic [15:0]  lc_wait_cyc;

    logic         b_tr_drdy, b_lc_drdy, b_ro_srdy, b_ro_eop;
    logic [W-1:0] b_ro_data;
    logic [1:0]   b_owner;
    logic [15:0]  b_lc_wait_cyc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ring_inject_arb #(.rdp_sz(W), .tw(2), .cnt_sz(4)) dut (
        .clk(clk), .reset(reset),
        .tr_srdy(tr_srdy), .tr_drdy(tr_drdy), .tr_data(tr_data), .tr_eop(tr_eop),
        .lc_srdy(lc_srdy), .lc_drdy(lc_drdy), .lc_data(lc_data), .lc_eop(lc_eop),
        .ro_srdy(ro_srdy), .ro_drdy(ro_drdy), .ro_data(ro_data), .ro_eop(ro_eop),
        .owner(owner), .lc_wait_cyc(lc_wait_cyc)
    );

    ring_inject_arb #(.rdp_sz(W), .tw(0), .cnt_sz(4)) dut_b (
        .clk(clk), .reset(reset),
        .tr_srdy(tr_srdy), .tr_drdy(b_tr_drdy), .tr_data(tr_data), .tr_eop(tr_eop),
        .lc_srdy(lc_srdy), .lc_drdy(b_lc_drdy), .lc_data(lc_data), .lc_eop(lc_eop),
        .ro_srdy(b_ro_srdy), .ro_drdy(ro_drdy), .ro_data(b_ro_data), .ro_eop(b_ro_eop),
        .owner(b_owner), .lc_wait_cyc(b_lc_wait_cyc)
    );

    typedef struct {
        logic         rst, ts, te, ls, le, rd;
        logic [W-1:0] td, ld;
        logic         es, ee, etr, elc;
        logic [W-1:0] ed;
        logic [1:0]   eo;
        int           ew;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, ts, te, input logic [W-1:0] td,
                       input logic ls, le, input logic [W-1:0] ld, input logic rd,
                       input logic es, input logic [W-1:0] ed, input logic ee, etr, elc,
                       input logic [1:0] eo, input int ew);
        vec_t v;
        v.rst = rst; v.ts = ts; v.te = te; v.td = td; v.ls = ls; v.le = le; v.ld = ld;
        v.rd = rd; v.es = es; v.ed = ed; v.ee = ee; v.etr = etr; v.elc = elc;
        v.eo = eo; v.ew = ew;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, ts, te, input logic [W-1:0] td,
                         input logic ls, le, input logic [W-1:0] ld, input logic rd);
        reset = rst; tr_srdy = ts; tr_eop = te; tr_data = td;
        lc_srdy = ls; lc_eop = le; lc_data = ld; ro_drdy = rd;
    endtask

    initial begin
        int wt;
        logic [W-1:0] td, ld;
        logic ls;

        drive(1, 0, 0, '0, 0, 0, '0, 0);
        @(posedge clk); #1;

        // reset with both sources requesting
        add(1, 1, 0, 16'hA000, 1, 0, 16'hB000, 1, 0, '0, 0, 0, 0, 2'b00, 0);

        // transit only: three 4-word packets
        for (int p = 0; p < 3; p++)
            for (int w = 0; w < 4; w++) begin
                td = 16'hA000 + W'(p * 16 + w);
                add(0, 1, w == 3, td, 0, 0, '0, 1, 1, td, w == 3, 1, 0,
                    (w == 3) ? 2'b00 : 2'b01, 0);
            end

        // weighted starvation with tw=2: T,T,L,T,T,L
        wt = 0;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 2; p++)
                for (int w = 0; w < 2; w++) begin
                    td = 16'hA100 + W'(r * 16 + p * 4 + w);
                    wt++;
                    add(0, 1, w == 1, td, 1, 1, 16'hB100 + W'(r), 1, 1, td, w == 1, 1, 0,
                        (w == 1) ? 2'b00 : 2'b01, wt);
                end
            ld = 16'hB100 + W'(r);
            add(0, 1, 0, 16'hA1F0, 1, 1, ld, 1, 1, ld, 1, 0, 1, 2'b00, wt);
        end

        // no interleave: local 5-word packet, transit arrives at word 2
        add(0, 0, 0, 16'hA200, 1, 0, 16'hB200, 1, 1, 16'hB200, 0, 0, 1, 2'b10, wt);
        for (int w = 1; w < 5; w++) begin
            ld = 16'hB200 + W'(w);
            add(0, 1, 0, 16'hA200, 1, w == 4, ld, 1, 1, ld, w == 4, 0, 1,
                (w == 4) ? 2'b00 : 2'b10, wt);
        end
        add(0, 1, 1, 16'hA200, 0, 0, '0, 1, 1, 16'hA200, 1, 1, 0, 2'b00, wt);

        // backpressure inside a locked transit packet, local waiting throughout
        add(1, 0, 0, '0, 0, 0, '0, 0, 0, '0, 0, 0, 0, 2'b00, 0);
        add(0, 1, 0, 16'hA300, 1, 0, 16'hB300, 0, 1, 16'hA300, 0, 0, 0, 2'b00, 1);
        add(0, 1, 0, 16'hA300, 1, 0, 16'hB300, 1, 1, 16'hA300, 0, 1, 0, 2'b01, 2);
        add(0, 1, 0, 16'hA301, 1, 0, 16'hB300, 1, 1, 16'hA301, 0, 1, 0, 2'b01, 3);
        add(0, 1, 0, 16'hA302, 1, 0, 16'hB300, 0, 1, 16'hA302, 0, 0, 0, 2'b01, 4);
        add(0, 1, 0, 16'hA302, 1, 0, 16'hB300, 0, 1, 16'hA302, 0, 0, 0, 2'b01, 5);
        add(0, 1, 0, 16'hA302, 1, 0, 16'hB300, 1, 1, 16'hA302, 0, 1, 0, 2'b01, 6);
        add(0, 1, 1, 16'hA303, 1, 0, 16'hB300, 1, 1, 16'hA303, 1, 1, 0, 2'b00, 7);
        add(0, 0, 0, '0, 1, 1, 16'hB300, 1, 1, 16'hB300, 1, 0, 1, 2'b00, 7);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ts, tbl[i].te, tbl[i].td,
                  tbl[i].ls, tbl[i].le, tbl[i].ld, tbl[i].rd);
            #1;
            chk($sformatf("v%0d ro_srdy", i), 32'(ro_srdy), 32'(tbl[i].es));
            chk($sformatf("v%0d tr_drdy", i), 32'(tr_drdy), 32'(tbl[i].etr));
            chk($sformatf("v%0d lc_drdy", i), 32'(lc_drdy), 32'(tbl[i].elc));
            if (tbl[i].es) begin
                chk($sformatf("v%0d ro_data", i), 32'(ro_data), 32'(tbl[i].ed));
                chk($sformatf("v%0d ro_eop", i), 32'(ro_eop), 32'(tbl[i].ee));
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d owner", i), 32'(owner), 32'(tbl[i].eo));
            if (tbl[i].ew >= 0)
                chk($sformatf("v%0d lc_wait_cyc", i), 32'(lc_wait_cyc), 32'(tbl[i].ew));
        end

        // reset in the middle of a locked local packet
        drive(0, 0, 0, '0, 1, 0, 16'hB400, 1);
        #1 chk("rst lc first word", 32'(lc_drdy), 32'd1);
        @(posedge clk); #1;
        chk("rst owner locked", 32'(owner), 32'(2'b10));
        drive(1, 1, 1, 16'hA400, 1, 0, 16'hB401, 1);
        #1;
        chk("rst tr_drdy", 32'(tr_drdy), 32'd0);
        chk("rst lc_drdy", 32'(lc_drdy), 32'd0);
        chk("rst ro_srdy", 32'(ro_srdy), 32'd0);
        chk("rst owner", 32'(owner), 32'(2'b00));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post-rst owner", 32'(owner), 32'(2'b00));
        chk("post-rst tr_drdy", 32'(tr_drdy), 32'd1);
        chk("post-rst lc_drdy", 32'(lc_drdy), 32'd0);
        chk("post-rst ro_data", 32'(ro_data), 32'(16'hA400));
        @(posedge clk); #1;
        chk("post-rst idle", 32'(owner), 32'(2'b00));

        // tw=0: local wins every contest with single-word packets
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            td = 16'hA500 + W'(i);
            ld = 16'hB500 + W'(i);
            ls = (i != 2 && i != 4);
            drive(0, 1, 1, td, ls, 1, ld, 1);
            #1;
            if (ls) begin
                chk($sformatf("tw0 %0d lc_drdy", i), 32'(b_lc_drdy), 32'd1);
                chk($sformatf("tw0 %0d tr_drdy", i), 32'(b_tr_drdy), 32'd0);
                chk($sformatf("tw0 %0d ro_data", i), 32'(b_ro_data), 32'(ld));
            end else begin
                chk($sformatf("tw0 %0d tr_drdy", i), 32'(b_tr_drdy), 32'd1);
                chk($sformatf("tw0 %0d ro_data", i), 32'(b_ro_data), 32'(td));
            end
            @(posedge clk); #1;
            chk($sformatf("tw0 %0d owner", i), 32'(b_owner), 32'(2'b00));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ring_inject_arb.md
# ring_inject_arb

Packet-level arbiter between transit ring traffic and local port injection in front of a ring tap's ring-out path. Transit packets have priority. A weighted anti-starvation counter forces a local grant after `tw` consecutive transit packets have been granted while local traffic was waiting. Ownership is locked from first word to `eop`, so packets never interleave on `ro`. The block sits between the tap's `sd_input` closures (ring-in, port-RX) and the ring-out `sd_output` closure, and is purely srdy/drdy on all sides.

## Interface
Parameters:
- `rdp_sz`, default `` `PRW_SZ ``: ring datapath width.
- `tw`, default 4: transit packets granted in a row while local waits before local is forced. 0 means local has absolute priority.
- `cnt_sz`, default 4: width of the weight counter. Requires `tw <= 2**cnt_sz-1`.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `tr_srdy` input 1: transit (ring-in) word valid.
- `tr_drdy` output 1: transit word accepted.
- `tr_data` input `rdp_sz`: transit word.
- `tr_eop` input 1: transit word is last of packet.
- `lc_srdy` input 1: local (port-RX) word valid.
- `lc_drdy` output 1: local word accepted.
- `lc_data` input `rdp_sz`: local word.
- `lc_eop` input 1: local word is last of packet.
- `ro_srdy` output 1: ring-out word valid.
- `ro_drdy` input 1: ring-out consumer ready.
- `ro_data` output `rdp_sz`: ring-out word, muxed from the granted source.
- `ro_eop` output 1: ring-out `eop`, muxed from the granted source.
- `owner` output 2: 00 idle, 01 transit locked, 10 local locked.
- `lc_wait_cyc` output 16: saturating count of cycles with `lc_srdy`=1 and `lc_drdy`=0.

## Operation
- States: IDLE, LOCK_TR, LOCK_LC. `owner` is the registered state encoding.
- **IDLE selection** is combinational, in this order:
  - Only `tr_srdy`: select transit.
  - Only `lc_srdy`: select local.
  - Both, with `wcnt < tw`: select transit.
  - Both, with `wcnt >= tw`: select local.
  - Neither: no selection; `ro_srdy`=0.
- **Datapath mux:** the selected source drives `ro_srdy`/`ro_data`/`ro_eop`. Its `drdy` equals `ro_drdy`; the other source's `drdy` is 0.
- **Transfer:** a transfer is `ro_srdy & ro_drdy`.
  - First-word transfer with `eop`=0: go to LOCK_TR or LOCK_LC per source.
  - First-word transfer with `eop`=1 (single-word packet): stay in IDLE.
- **LOCK_x:** only the owner is muxed; the other side is held off (`drdy`=0) regardless of its `srdy`. A transfer with `eop`=1 returns to IDLE.
- **Weight counter `wcnt`** (`cnt_sz` bits) updates only on a first-word transfer in IDLE:
  - Transit granted with `lc_srdy`=1: `wcnt` <= min(`wcnt`+1, `tw`).
  - Transit granted with `lc_srdy`=0: `wcnt` holds.
  - Local granted: `wcnt` <= 0.
- **`lc_wait_cyc`** increments when `lc_srdy & !lc_drdy`, and saturates at 16'hFFFF.
- **Reset** (synchronous) sets state to IDLE, `wcnt`=0, `lc_wait_cyc`=0. While `reset`=1: `tr_drdy`=`lc_drdy`=`ro_srdy`=0 and `owner`=00. `ro_data`/`ro_eop` are don't-care while `ro_srdy`=0.
- **Reset mid-packet** abandons the lock. The next packet is arbitrated fresh, and no recovery of the partial packet is attempted; upstream framing is the source's responsibility.

## Timing
- Zero-cycle combinational path from `*_srdy`/`*_data` to `ro_*`, and from `ro_drdy` to the granted `*_drdy`. The surrounding `sd_input`/`sd_output` closures register both sides.
- Arbitration decision is made in the same cycle as the first word's transfer. State and `wcnt` update on the following edge.
- Back-to-back packets: `eop` transfer in cycle N, and the next packet's first word may transfer in cycle N+1, with no bubble.
- `ro_drdy`=0 stalls the owner with no state change. A selection in IDLE without a transfer is not committed and is re-evaluated next cycle.
- `srdy` of the non-owner has no effect until IDLE.

## Test plan
- **Transit only.** Three 4-word transit packets with `ro_drdy`=1 -> 12 consecutive transfers; `owner` = 01 during words 2-4 and 00 after each `eop`; `lc_drdy` stays 0.
- **Weighted starvation, `tw`=2.** `lc_srdy` held high while transit sends continuous 2-word packets -> grant order T,T,L,T,T,L; `wcnt` sequence 1,2,0,1,2,0.
- **No interleave.** Local 5-word packet locked at word 1, then `tr_srdy` rises at word 2 -> `tr_drdy`=0 through local `eop`; transit's first word transfers the cycle after local `eop`.
- **Backpressure.** `ro_drdy` toggles 1,0,0,1 during a locked transit packet -> `ro_data` holds the stalled word; `lc_wait_cyc` increments every cycle `lc_srdy`=1.
- **Single-word packets, `tw`=0.** Both sources send 1-word packets -> local wins every contest, state never leaves IDLE, and transit transfers only when `lc_srdy`=0.
- **Reset mid-packet.** Assert `reset` during word 2 of a locked local packet -> next cycle all `drdy`/`ro_srdy`=0 and `owner`=00; after release, a pending transit packet is granted first (`wcnt`=0 < `tw`).
